// File: rtl/dma_reg_pkg.sv
// Shared types and constants for the DMA peripheral slice.
package dma_reg_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        ACK  = 2'd2,
        DONE = 2'd3
    } periph_state_t;

    localparam logic DIR_DEV2MEM = 1'b0;
    localparam logic DIR_MEM2DEV = 1'b1;

    // True when the FIFO can make progress on the bus in direction dir:
    // something to send (dev->mem) or room to receive (mem->dev).
    function automatic logic demand(input logic dir, input int unsigned cnt,
                                    input int unsigned depth);
        if (dir == DIR_MEM2DEV) return cnt < depth;
        else                    return cnt >= 1;
    endfunction

endpackage

// File: rtl/dma_periph_fifo.sv
// Byte FIFO, power-of-two DEPTH, synchronous active-low reset.
// Pushes when full and pops when empty are dropped here as a last guard.
module dma_periph_fifo #(
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic [7:0]    wdata,
    output logic [7:0]    head,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

    // Pointer and occupancy update; AW-bit pointers wrap modulo DEPTH.
    always_comb begin
        do_push  = push & ~full;
        do_pop   = pop & ~empty;
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
    end

    // Control state; storage is not reset since count gates its visibility.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage write.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/dma_peripheral.sv
// 8237-style DMA peripheral: demand-mode DREQ/DACK handshake around a byte FIFO.
// Optional DMA_PERIPH_ERR_EN: sticky ERR on strobes that hit an empty/full FIFO.
module dma_peripheral
    import dma_reg_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic       DIR,
    output logic       DREQ,
    input  logic       DACK,
    input  logic       IOR_N,
    input  logic       IOW_N,
    input  logic       EOP_N,
    inout  wire  [7:0] DB,
    input  logic [7:0] SRC_DATA,
    input  logic       SRC_VALID,
    output logic       SRC_READY,
    output logic [7:0] SNK_DATA,
    output logic       SNK_VALID,
    input  logic       SNK_READY,
    output logic       TC_SEEN,
    output logic       ERR
);

    localparam int CW = $clog2(DEPTH) + 1;

    periph_state_t state_q, state_d;
    logic          dir_q, dir_d, dir_cur;
    logic          dreq_q, dreq_d;
    logic          tc_q, tc_d;
    logic          run_q;
    logic          ior_prev_q, iow_prev_q;
    logic [7:0]    db_q, db_d;

    logic [7:0]    fifo_head;
    logic [CW-1:0] fifo_count, count_nxt;
    logic          fifo_full, fifo_empty;
    logic          fifo_push, fifo_pop;
    logic          byte_done, push_src, push_bus, pop_bus, pop_snk;

    // Direction is only sampled while idle; a transfer keeps the latched one.
    assign dir_cur = (state_q == IDLE) ? DIR : dir_q;

    // run_q holds the local handshakes low for the cycle after reset.
    assign SRC_READY = run_q & (dir_cur == DIR_DEV2MEM) & ~fifo_full;
    assign SNK_VALID = run_q & (dir_cur == DIR_MEM2DEV) & ~fifo_empty;
    assign SNK_DATA  = fifo_empty ? 8'h00 : fifo_head;
    assign DREQ      = dreq_q;
    assign TC_SEEN   = tc_q;

    assign DB = (dir_q == DIR_DEV2MEM && state_q == ACK && DACK && !IOR_N)
                ? fifo_head : 8'hzz;

    // Strobe edges, FIFO traffic and the post-transfer occupancy.
    always_comb begin
        dir_d     = dir_cur;
        byte_done = DACK & ((dir_cur == DIR_MEM2DEV) ? (~iow_prev_q & IOW_N)
                                                     : (~ior_prev_q & IOR_N));
        db_d      = (dir_cur == DIR_MEM2DEV && DACK && !IOW_N) ? DB : db_q;
        push_src  = SRC_VALID & SRC_READY;
        pop_snk   = SNK_VALID & SNK_READY;
        pop_bus   = byte_done & (dir_cur == DIR_DEV2MEM) & ~fifo_empty;
        push_bus  = byte_done & (dir_cur == DIR_MEM2DEV) & ~fifo_full;
        fifo_push = push_src | push_bus;
        fifo_pop  = pop_bus | pop_snk;
        count_nxt = fifo_count + CW'(fifo_push) - CW'(fifo_pop);
    end

    // Next state plus the registered outputs derived from it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (demand(dir_cur, 32'(fifo_count), DEPTH)) state_d = REQ;
            REQ:  if (DACK) state_d = ACK;
            ACK: begin
                if (!EOP_N)     state_d = DONE;
                else if (!DACK) state_d = IDLE;
                else if (byte_done && !demand(dir_cur, 32'(count_nxt), DEPTH))
                    state_d = IDLE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        dreq_d = (state_d == REQ) || (state_d == ACK);
        tc_d   = (state_d == DONE);
    end

    // FSM and bus-side registers; reset also forgets any half-seen strobe.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_q    <= IDLE;
            dir_q      <= DIR_DEV2MEM;
            dreq_q     <= 1'b0;
            tc_q       <= 1'b0;
            run_q      <= 1'b0;
            ior_prev_q <= 1'b1;
            iow_prev_q <= 1'b1;
            db_q       <= 8'h00;
        end else begin
            state_q    <= state_d;
            dir_q      <= dir_d;
            dreq_q     <= dreq_d;
            tc_q       <= tc_d;
            run_q      <= 1'b1;
            ior_prev_q <= IOR_N;
            iow_prev_q <= IOW_N;
            db_q       <= db_d;
        end
    end

`ifdef DMA_PERIPH_ERR_EN
    logic err_q, err_d;

    // Sticky flag for a completed strobe the FIFO could not serve.
    always_comb begin
        err_d = err_q | (byte_done & ((dir_cur == DIR_MEM2DEV) ? fifo_full
                                                               : fifo_empty));
    end

    // Error flag register.
    always_ff @(posedge CLK) begin
        if (!RESET_N) err_q <= 1'b0;
        else          err_q <= err_d;
    end

    assign ERR = err_q;
`else
    assign ERR = 1'b0;
`endif

    dma_periph_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (CLK),
        .rst_n (RESET_N),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata ((dir_cur == DIR_MEM2DEV) ? db_q : SRC_DATA),
        .head  (fifo_head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule

// File: tb/tb_dma_peripheral.sv
// Directed bench for dma_peripheral (DEPTH=8). DB has pull-ups, so a
// released bus reads 8'hFF.
module tb_dma_peripheral;

    logic       CLK = 1'b0;
    logic       RESET_N, DIR, DACK, IOR_N, IOW_N, EOP_N;
    logic       DREQ, SRC_READY, SNK_VALID, TC_SEEN, ERR;
    logic [7:0] SRC_DATA, SNK_DATA;
    logic       SRC_VALID, SNK_READY;
    wire  [7:0] DB;
    logic       tb_drv;
    logic [7:0] tb_db;
    int         errors = 0;
    int         checks = 0;

`ifdef DMA_PERIPH_ERR_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    always #5 CLK = ~CLK;

    assign DB = tb_drv ? tb_db : 8'hzz;
    for (genvar g = 0; g < 8; g++) begin : g_pu
        pullup (DB[g]);
    end

    dma_peripheral #(.DEPTH(8)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .DIR(DIR), .DREQ(DREQ), .DACK(DACK),
        .IOR_N(IOR_N), .IOW_N(IOW_N), .EOP_N(EOP_N), .DB(DB),
        .SRC_DATA(SRC_DATA), .SRC_VALID(SRC_VALID), .SRC_READY(SRC_READY),
        .SNK_DATA(SNK_DATA), .SNK_VALID(SNK_VALID), .SNK_READY(SNK_READY),
        .TC_SEEN(TC_SEEN), .ERR(ERR)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        RESET_N = 0; DIR = 0; DACK = 0; IOR_N = 1; IOW_N = 1; EOP_N = 1;
        SRC_DATA = 8'h00; SRC_VALID = 0; SNK_READY = 0; tb_drv = 0; tb_db = 8'h00;
        tick(); tick();
        chk("rst_dreq", DREQ, 0);
        chk("rst_tc", TC_SEEN, 0);
        chk("rst_err", ERR, 0);
        chk("rst_src_ready", SRC_READY, 0);
        chk("rst_snk_valid", SNK_VALID, 0);
        chk("rst_snk_data", SNK_DATA, 8'h00);
        chk("rst_db", DB, 8'hFF);
        chk("rst_count", dut.fifo_count, 0);
        RESET_N = 1; tick();
        chk("idle_src_ready", SRC_READY, 1);
        chk("idle_dreq", DREQ, 0);

        // Dev->mem: two bytes, two IOR_N pulses.
        SRC_DATA = 8'hA5; SRC_VALID = 1; tick();
        chk("s1_dreq_early", DREQ, 0);
        SRC_DATA = 8'h3C; tick();
        chk("s1_dreq_up", DREQ, 1);
        chk("s1_count2", dut.fifo_count, 2);
        SRC_VALID = 0; DACK = 1; tick();
        IOR_N = 0; #1 chk("s1_db_a5", DB, 8'hA5);
        tick(); IOR_N = 1; tick();
        chk("s1_count1", dut.fifo_count, 1);
        chk("s1_dreq_hold", DREQ, 1);
        IOR_N = 0; #1 chk("s1_db_3c", DB, 8'h3C);
        tick(); IOR_N = 1; tick();
        chk("s1_dreq_fall", DREQ, 0);
        chk("s1_count0", dut.fifo_count, 0);
        chk("s1_db_release", DB, 8'hFF);
        DACK = 0; tick();

        // Dev->mem with EOP on the second rising strobe.
        SRC_VALID = 1;
        for (int i = 1; i <= 4; i++) begin
            SRC_DATA = 8'(i * 8'h11); tick();
        end
        SRC_VALID = 0; DACK = 1; tick();
        IOR_N = 0; tick(); IOR_N = 1; tick();
        chk("s3_count3", dut.fifo_count, 3);
        IOR_N = 0; #1 chk("s3_db_22", DB, 8'h22);
        tick(); IOR_N = 1; EOP_N = 0; tick();
        chk("s3_tc_hi", TC_SEEN, 1);
        chk("s3_count2", dut.fifo_count, 2);
        chk("s3_dreq_done", DREQ, 0);
        EOP_N = 1; DACK = 0; tick();
        chk("s3_tc_lo", TC_SEEN, 0);
        tick();
        chk("s3_dreq_reassert", DREQ, 1);

        // Reset in ACK with five bytes queued.
        SRC_VALID = 1;
        for (int i = 5; i <= 7; i++) begin
            SRC_DATA = 8'(i * 8'h11); tick();
        end
        SRC_VALID = 0;
        chk("s6_count5", dut.fifo_count, 5);
        DACK = 1; tick();
        IOR_N = 0; #1 chk("s6_db_33", DB, 8'h33);
        RESET_N = 0; tick();
        chk("s6_dreq", DREQ, 0);
        chk("s6_count", dut.fifo_count, 0);
        chk("s6_db_z", DB, 8'hFF);
        RESET_N = 1; IOR_N = 1; DACK = 0; tick();

        // Strobe against an empty FIFO.
        DACK = 1; IOR_N = 0; tick(); IOR_N = 1; tick();
        chk("err_set", ERR, ERR_EXP);
        chk("err_count", dut.fifo_count, 0);
        DACK = 0; tick(); tick();
        chk("err_sticky", ERR, ERR_EXP);

        // Mem->dev, fill all eight entries.
        RESET_N = 0; DIR = 1; tick();
        chk("s2_err_clr", ERR, 0);
        RESET_N = 1; tick();
        chk("s2_dreq_up", DREQ, 1);
        chk("s2_snk_valid0", SNK_VALID, 0);
        DACK = 1; tick();
        for (int i = 1; i <= 8; i++) begin
            tb_drv = 1; tb_db = 8'(i); IOW_N = 0; tick();
            IOW_N = 1; tb_drv = 0; tick();
            chk("s2_count", dut.fifo_count, 32'(i));
            chk("s2_dreq", DREQ, (i < 8) ? 1 : 0);
        end
        DACK = 0; tick();
        SNK_READY = 1;
        for (int i = 1; i <= 8; i++) begin
            chk("s2_snk_valid", SNK_VALID, 1);
            chk("s2_snk_data", SNK_DATA, 32'(i));
            tick();
        end
        SNK_READY = 0;
        chk("s2_snk_empty", SNK_VALID, 0);
        chk("s2_snk_data0", SNK_DATA, 8'h00);

        // Mem->dev, DACK withdrawn after three bytes.
        tick();
        chk("s4_dreq", DREQ, 1);
        DACK = 1; tick();
        for (int i = 1; i <= 3; i++) begin
            tb_drv = 1; tb_db = 8'(8'hA0 + i); IOW_N = 0; tick();
            IOW_N = 1; tb_drv = 0; tick();
        end
        DACK = 0; tick();
        chk("s4_dreq_drop", DREQ, 0);
        chk("s4_count3", dut.fifo_count, 3);
        tb_drv = 1; tb_db = 8'h5A; IOW_N = 0; tick();
        IOW_N = 1; tb_drv = 0; tick();
        chk("s4_no_push", dut.fifo_count, 3);
        chk("s4_head", SNK_DATA, 8'hA1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
